// File: rtl/udp_fragment_slot_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_fragment_pkg
// Description : Shared types and helpers for the UDP fragment slot bank.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_fragment_pkg;

    localparam int FRAGMENT_ID_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        DISCARD = 3'd2,
        FLUSH   = 3'd3,
        QUEUED  = 3'd4,
        DRAIN   = 3'd5
    } slot_state_type;

    function automatic int slot_index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_fragment_slot_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : udp_fragment_slot_bank_if
// Description : Capture input and drain output bundle of the fragment bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface udp_fragment_slot_bank_if
    import udp_fragment_pkg::*;
#(
    parameter int SLOT_COUNT = 4,
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0]        data;
    logic                         data_enable;
    logic                         data_last;
    logic [FRAGMENT_ID_WIDTH-1:0] fragment_id;
    logic                         push_data_enable;
    logic                         ready;
    logic                         data_ready;
    logic [DATA_WIDTH:0]          push_data;
    logic                         push_data_valid;
    logic [FRAGMENT_ID_WIDTH-1:0] current_packet_id;
    logic                         drop;
    logic [SLOT_COUNT-1:0]        slot_busy;

    modport master (
        output data, data_enable, data_last, fragment_id, push_data_enable,
        input  ready, data_ready, push_data, push_data_valid,
               current_packet_id, drop, slot_busy
    );

    modport slave (
        input  data, data_enable, data_last, fragment_id, push_data_enable,
        output ready, data_ready, push_data, push_data_valid,
               current_packet_id, drop, slot_busy
    );

endinterface
`default_nettype wire

// File: rtl/synchronous_fifo.sv
`default_nettype none
// ============================================================================
// Module      : synchronous_fifo
// Description : Single-clock first-word-fall-through FIFO, power-of-two depth.
// Revision    : 1.0 - initial release
// ============================================================================
module synchronous_fifo #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 16,
    parameter int XILINX     = 0
) (
    input  wire logic                  clock,
    input  wire logic                  reset_n,
    input  wire logic                  i_write_enable,
    input  wire logic [DATA_WIDTH-1:0] i_write_data,
    input  wire logic                  i_read_enable,
    output logic      [DATA_WIDTH-1:0] o_read_data,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int c_addr_width = $clog2(DEPTH);

    logic [c_addr_width:0] r_write_ptr;
    logic [c_addr_width:0] r_read_ptr;
    logic                  w_write;
    logic                  w_read;

    assign o_empty = (r_write_ptr == r_read_ptr);
    assign o_full  = (r_write_ptr[c_addr_width] != r_read_ptr[c_addr_width]) &&
                     (r_write_ptr[c_addr_width-1:0] == r_read_ptr[c_addr_width-1:0]);
    assign w_write = i_write_enable && !o_full;
    assign w_read  = i_read_enable && !o_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write_ptr <= '0;
            r_read_ptr  <= '0;
        end else begin
            if (w_write) r_write_ptr <= r_write_ptr + 1'b1;
            if (w_read)  r_read_ptr  <= r_read_ptr + 1'b1;
        end
    end

    // Asynchronous read keeps the head word visible without a read strobe.
    generate
        if (XILINX != 0) begin : g_xilinx_ram
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clock) begin
                if (w_write) r_mem[r_write_ptr[c_addr_width-1:0]] <= i_write_data;
            end
            assign o_read_data = r_mem[r_read_ptr[c_addr_width-1:0]];
        end else begin : g_generic_ram
            logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            always_ff @(posedge clock) begin
                if (w_write) r_mem[r_write_ptr[c_addr_width-1:0]] <= i_write_data;
            end
            assign o_read_data = r_mem[r_read_ptr[c_addr_width-1:0]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/udp_fragment_slot_bank_lane.sv
`default_nettype none
// ============================================================================
// Module      : udp_fragment_lane
// Description : One fragment slot: state machine, id register, FIFO and the
//               optional idle timeout (UDP_FRAGMENT_SLOT_BANK_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module udp_fragment_lane
    import udp_fragment_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int SLOT_DEPTH     = 4096,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int XILINX         = 0
) (
    input  wire logic                         clock,
    input  wire logic                         reset,
    input  wire logic                         i_claim,
    input  wire logic [FRAGMENT_ID_WIDTH-1:0] i_claim_id,
    input  wire logic                         i_write_valid,
    input  wire logic [DATA_WIDTH:0]          i_write_word,
    input  wire logic                         i_write_last,
    input  wire logic                         i_start_drain,
    input  wire logic                         i_read_enable,
    output slot_state_type                    o_state,
    output logic      [FRAGMENT_ID_WIDTH-1:0] o_packet_id,
    output logic      [DATA_WIDTH:0]          o_read_word,
    output logic                              o_read_valid,
    output logic                              o_queued_event,
    output logic                              o_drop_event,
    output logic                              o_drain_done
);

    slot_state_type               r_state;
    slot_state_type               w_state_next;
    logic [FRAGMENT_ID_WIDTH-1:0] r_packet_id;
    logic                         w_fifo_write;
    logic                         w_fifo_read;
    logic                         w_fifo_empty;
    logic                         w_fifo_full;
    logic                         w_timeout_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_packet_id <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && i_claim) r_packet_id <= i_claim_id;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_fifo_write   = 1'b0;
        w_fifo_read    = 1'b0;
        o_queued_event = 1'b0;
        o_drop_event   = 1'b0;
        o_drain_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_claim) w_state_next = CAPTURE;
            end
            CAPTURE: begin
                if (i_write_valid) begin
                    if (w_fifo_full) begin
                        w_state_next = i_write_last ? FLUSH : DISCARD;
                        o_drop_event = i_write_last;
                    end else begin
                        w_fifo_write = 1'b1;
                        if (i_write_last) begin
                            w_state_next   = QUEUED;
                            o_queued_event = 1'b1;
                        end
                    end
                end else if (w_timeout_hit) begin
                    w_state_next = FLUSH;
                    o_drop_event = 1'b1;
                end
            end
            DISCARD: begin
                if (i_write_valid && i_write_last) begin
                    w_state_next = FLUSH;
                    o_drop_event = 1'b1;
                end
            end
            FLUSH: begin
                w_fifo_read = !w_fifo_empty;
                if (w_fifo_empty) w_state_next = IDLE;
            end
            QUEUED: begin
                if (i_start_drain) w_state_next = DRAIN;
            end
            DRAIN: begin
                w_fifo_read = i_read_enable && !w_fifo_empty;
                if (w_fifo_empty) begin
                    w_state_next = IDLE;
                    o_drain_done = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef UDP_FRAGMENT_SLOT_BANK_TIMEOUT_EN
    localparam int c_count_width = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_count_width-1:0] r_idle_count;

    // Counts capture cycles with no accepted beat; saturates at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idle_count <= '0;
        end else if (r_state != CAPTURE || i_write_valid) begin
            r_idle_count <= '0;
        end else if (!w_timeout_hit) begin
            r_idle_count <= r_idle_count + 1'b1;
        end
    end

    assign w_timeout_hit = (r_idle_count == c_count_width'(TIMEOUT_CYCLES));
`else
    assign w_timeout_hit = 1'b0;
`endif

    synchronous_fifo #(
        .DATA_WIDTH(DATA_WIDTH + 1),
        .DEPTH     (SLOT_DEPTH),
        .XILINX    (XILINX)
    ) u_fifo (
        .clock         (clock),
        .reset_n       (~reset),
        .i_write_enable(w_fifo_write),
        .i_write_data  (i_write_word),
        .i_read_enable (w_fifo_read),
        .o_read_data   (o_read_word),
        .o_empty       (w_fifo_empty),
        .o_full        (w_fifo_full)
    );

    assign o_state      = r_state;
    assign o_packet_id  = r_packet_id;
    assign o_read_valid = (r_state == DRAIN) && !w_fifo_empty;

endmodule
`default_nettype wire

// File: rtl/udp_fragment_slot_bank.sv
`default_nettype none
// ============================================================================
// Module      : udp_fragment_slot_bank
// Description : Multi-slot UDP fragment capture buffer releasing fragments in
//               completion order. Optional idle timeout via macro
//               UDP_FRAGMENT_SLOT_BANK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_fragment_slot_bank
    import udp_fragment_pkg::*;
#(
    parameter int SLOT_COUNT     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SLOT_DEPTH     = 4096,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int XILINX         = 0
) (
    input  wire logic                clock,
    input  wire logic                reset,
    udp_fragment_slot_bank_if.slave  bus
);

    localparam int c_index_width  = slot_index_width(SLOT_COUNT);
    localparam int c_credit_width = c_index_width + 2;

    slot_state_type               w_lane_state [SLOT_COUNT];
    logic [FRAGMENT_ID_WIDTH-1:0] w_lane_id    [SLOT_COUNT];
    logic [DATA_WIDTH:0]          w_lane_word  [SLOT_COUNT];
    logic [SLOT_COUNT-1:0]        w_lane_valid;
    logic [SLOT_COUNT-1:0]        w_lane_idle;
    logic [SLOT_COUNT-1:0]        w_claim;
    logic [SLOT_COUNT-1:0]        w_start;
    logic [SLOT_COUNT-1:0]        w_queued_event;
    logic [SLOT_COUNT-1:0]        w_drop_event;
    logic [SLOT_COUNT-1:0]        w_done_event;

    logic                         r_in_fragment;
    logic                         r_dropping;
    logic [c_index_width-1:0]     r_current_slot;
    logic                         r_write_valid;
    logic [c_index_width-1:0]     r_write_slot;
    logic [DATA_WIDTH:0]          r_write_word;
    logic                         r_write_last;

    logic                         w_first_beat;
    logic                         w_free_found;
    logic [c_index_width-1:0]     w_free_index;
    logic                         w_alloc_drop;
    logic                         w_accept;
    logic [c_index_width-1:0]     w_beat_slot;

    logic [c_index_width-1:0]     r_queue [SLOT_COUNT];
    logic [c_index_width-1:0]     r_queue_head;
    logic [c_index_width-1:0]     r_queue_tail;
    logic [c_index_width:0]       r_queue_count;
    logic [c_index_width-1:0]     w_push_index;
    logic                         w_queue_push;
    logic                         w_queue_pop;
    logic [c_index_width-1:0]     w_head;
    logic                         w_head_draining;

    logic [c_credit_width-1:0]    r_drop_credit;
    logic [c_credit_width-1:0]    w_drop_total;
    logic                         r_drop;
    logic                         r_ready;
    logic                         r_data_ready;
    logic [SLOT_COUNT-1:0]        r_slot_busy;

    function automatic logic [c_index_width-1:0] advance(input logic [c_index_width-1:0] ptr);
        return (ptr == c_index_width'(SLOT_COUNT - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Allocation is decided combinationally on the first beat, lowest IDLE slot.
    always_comb begin
        w_first_beat = bus.data_enable && !r_in_fragment;
        w_free_found = 1'b0;
        w_free_index = '0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (w_lane_idle[i]) begin
                w_free_found = 1'b1;
                w_free_index = c_index_width'(i);
            end
        end
        w_claim = '0;
        if (w_first_beat && w_free_found) w_claim[w_free_index] = 1'b1;
        w_alloc_drop = w_first_beat && !w_free_found;
        w_accept     = (w_first_beat && w_free_found) ||
                       (bus.data_enable && r_in_fragment && !r_dropping);
        w_beat_slot  = r_in_fragment ? r_current_slot : w_free_index;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_fragment  <= 1'b0;
            r_dropping     <= 1'b0;
            r_current_slot <= '0;
            r_write_valid  <= 1'b0;
            r_write_slot   <= '0;
            r_write_word   <= '0;
            r_write_last   <= 1'b0;
        end else begin
            if (bus.data_enable) begin
                if (bus.data_last) begin
                    r_in_fragment <= 1'b0;
                    r_dropping    <= 1'b0;
                end else if (!r_in_fragment) begin
                    r_in_fragment  <= 1'b1;
                    r_dropping     <= !w_free_found;
                    r_current_slot <= w_free_index;
                end
            end
            r_write_valid <= w_accept;
            r_write_slot  <= w_beat_slot;
            r_write_word  <= {w_first_beat, bus.data};
            r_write_last  <= bus.data_last;
        end
    end

    generate
        for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : g_lane
            assign w_lane_idle[gi] = (w_lane_state[gi] == IDLE);
            assign w_start[gi]     = (r_queue_count != '0) && (w_head == c_index_width'(gi)) &&
                                     (w_lane_state[gi] == QUEUED);

            udp_fragment_lane #(
                .DATA_WIDTH    (DATA_WIDTH),
                .SLOT_DEPTH    (SLOT_DEPTH),
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
                .XILINX        (XILINX)
            ) u_lane (
                .clock         (clock),
                .reset         (reset),
                .i_claim       (w_claim[gi]),
                .i_claim_id    (bus.fragment_id),
                .i_write_valid (r_write_valid && (r_write_slot == c_index_width'(gi))),
                .i_write_word  (r_write_word),
                .i_write_last  (r_write_last),
                .i_start_drain (w_start[gi]),
                .i_read_enable (bus.push_data_enable && w_head_draining &&
                                (w_head == c_index_width'(gi))),
                .o_state       (w_lane_state[gi]),
                .o_packet_id   (w_lane_id[gi]),
                .o_read_word   (w_lane_word[gi]),
                .o_read_valid  (w_lane_valid[gi]),
                .o_queued_event(w_queued_event[gi]),
                .o_drop_event  (w_drop_event[gi]),
                .o_drain_done  (w_done_event[gi])
            );
        end
    endgenerate

    // The head entry stays in the queue until its slot finishes draining.
    always_comb begin
        w_push_index = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (w_queued_event[i]) w_push_index = c_index_width'(i);
        end
    end

    assign w_queue_push    = |w_queued_event;
    assign w_queue_pop     = |w_done_event;
    assign w_head          = r_queue[r_queue_head];
    assign w_head_draining = (r_queue_count != '0) && (w_lane_state[w_head] == DRAIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOT_COUNT; i++) r_queue[i] <= '0;
            r_queue_head  <= '0;
            r_queue_tail  <= '0;
            r_queue_count <= '0;
        end else begin
            if (w_queue_push) begin
                r_queue[r_queue_tail] <= w_push_index;
                r_queue_tail          <= advance(r_queue_tail);
            end
            if (w_queue_pop) r_queue_head <= advance(r_queue_head);
            case ({w_queue_push, w_queue_pop})
                2'b10:   r_queue_count <= r_queue_count + 1'b1;
                2'b01:   r_queue_count <= r_queue_count - 1'b1;
                default: r_queue_count <= r_queue_count;
            endcase
        end
    end

    // Coincident drop events are spread over consecutive cycles, one pulse each.
    assign w_drop_total = r_drop_credit +
                          c_credit_width'($countones(w_drop_event)) +
                          c_credit_width'(w_alloc_drop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_credit <= '0;
            r_drop        <= 1'b0;
            r_ready       <= 1'b0;
            r_data_ready  <= 1'b0;
            r_slot_busy   <= '0;
        end else begin
            r_drop        <= (w_drop_total != '0);
            r_drop_credit <= (w_drop_total != '0) ? w_drop_total - 1'b1 : '0;
            r_ready       <= |w_lane_idle;
            r_data_ready  <= w_head_draining;
            r_slot_busy   <= ~w_lane_idle;
        end
    end

    assign bus.ready             = r_ready;
    assign bus.data_ready        = r_data_ready;
    assign bus.drop              = r_drop;
    assign bus.slot_busy         = r_slot_busy;
    assign bus.push_data         = w_head_draining ? w_lane_word[w_head] : '0;
    assign bus.push_data_valid   = w_head_draining && w_lane_valid[w_head];
    assign bus.current_packet_id = w_head_draining ? w_lane_id[w_head] : '0;

endmodule
`default_nettype wire

// File: tb/tb_udp_fragment_slot_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_fragment_slot_bank
// Description : Self-checking bench with a fragment-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_fragment_slot_bank;
    import udp_fragment_pkg::*;

    localparam int SLOTS = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TMO   = 50;

    typedef struct {
        logic [DW:0]  word;
        logic [15:0]  id;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks     = 0;
    int   failures   = 0;
    int   drops_seen = 0;
    int   drain_mode = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    udp_fragment_slot_bank_if #(.SLOT_COUNT(SLOTS), .DATA_WIDTH(DW)) bus ();

    udp_fragment_slot_bank #(
        .SLOT_COUNT    (SLOTS),
        .DATA_WIDTH    (DW),
        .SLOT_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .XILINX        (0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one fragment; kept fragments are appended to the expected stream.
    task automatic send_fragment(input logic [15:0] id, input int len, input bit keep,
                                 input bit gaps, input bit counting);
        for (int b = 0; b < len; b++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    bus.data_enable = 1'b0;
                    bus.data_last   = 1'b0;
                    tick();
                end
            end
            bus.data_enable = 1'b1;
            bus.data        = counting ? DW'(b) : DW'($urandom);
            bus.data_last   = (b == len - 1);
            bus.fragment_id = (b == 0) ? id : 16'($urandom);
            if (keep) exp_q.push_back('{word: {(b == 0), bus.data}, id: id});
            tick();
        end
        bus.data_enable = 1'b0;
        bus.data_last   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        tick(3);
        while ((exp_q.size() != 0 || bus.slot_busy != '0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain_bound"}, 32'(n < budget), 32'd1);
        tick(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},      32'(bus.ready),             32'd0);
        check({tag, "_data_ready"}, 32'(bus.data_ready),        32'd0);
        check({tag, "_push_data"},  32'(bus.push_data),         32'd0);
        check({tag, "_valid"},      32'(bus.push_data_valid),   32'd0);
        check({tag, "_id"},         32'(bus.current_packet_id), 32'd0);
        check({tag, "_drop"},       32'(bus.drop),              32'd0);
        check({tag, "_busy"},       32'(bus.slot_busy),         32'd0);
    endtask

    initial begin
        bus.push_data_enable = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (drain_mode == 1)      bus.push_data_enable = 1'b1;
            else if (drain_mode == 2) bus.push_data_enable = 1'($urandom_range(0, 1));
            else                      bus.push_data_enable = 1'b0;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.drop) drops_seen++;
            if (!reset && bus.push_data_valid && bus.push_data_enable) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_output observed=%0h expected=none", bus.push_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (bus.push_data === e.word) else begin
                        failures++;
                        $error("FAIL push_data observed=%0h expected=%0h", bus.push_data, e.word);
                    end
                    checks++;
                    assert (bus.current_packet_id === e.id) else begin
                        failures++;
                        $error("FAIL packet_id observed=%0h expected=%0h", bus.current_packet_id, e.id);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0;
        int   n;
        int   free_slots;
        int   exp_drops;
        int   len;
        int   k;
        int   hit;
        bit   keep;
        logic [15:0] id;

        bus.data        = '0;
        bus.data_enable = 1'b0;
        bus.data_last   = 1'b0;
        bus.fragment_id = '0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);
        check("ready_after_reset", 32'(bus.ready), 32'd1);
        check("busy_after_reset", 32'(bus.slot_busy), 32'd0);

        // Single counting fragment drained continuously.
        drain_mode = 1;
        d0 = drops_seen;
        send_fragment(16'h1234, 10, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (!bus.data_ready && n < 30) begin
            tick();
            n++;
        end
        check("single_data_ready", 32'(bus.data_ready), 32'd1);
        wait_idle("single", 200);
        check("single_no_drop", 32'(drops_seen - d0), 32'd0);

        // Fill every slot, then a fifth fragment must be discarded whole.
        drain_mode = 0;
        d0 = drops_seen;
        for (int f = 0; f < SLOTS; f++) begin
            send_fragment(16'($urandom), $urandom_range(1, DEPTH), 1'b1, 1'b1, 1'b0);
            tick(2);
        end
        tick(4);
        check("full_busy", 32'(bus.slot_busy), 32'hF);
        check("full_ready", 32'(bus.ready), 32'd0);
        send_fragment(16'hDEAD, 5, 1'b0, 1'b0, 1'b0);
        tick(4);
        check("full_drop", 32'(drops_seen - d0), 32'd1);
        check("full_busy_kept", 32'(bus.slot_busy), 32'hF);
        drain_mode = 2;
        wait_idle("full", 1000);
        check("full_ready_back", 32'(bus.ready), 32'd1);

        // Overflow: nothing presented downstream, one drop.
        drain_mode = 1;
        d0 = drops_seen;
        send_fragment(16'h0BAD, 20, 1'b0, 1'b0, 1'b0);
        wait_idle("overflow", 200);
        check("overflow_drop", 32'(drops_seen - d0), 32'd1);

        // Randomized rounds against the fragment-level model.
        for (int r = 0; r < 8; r++) begin
            drain_mode = 0;
            d0 = drops_seen;
            free_slots = SLOTS;
            exp_drops = 0;
            k = $urandom_range(2, 6);
            for (int f = 0; f < k; f++) begin
                len = $urandom_range(1, DEPTH + 8);
                id  = 16'($urandom);
                if (free_slots == 0 || len > DEPTH) begin
                    keep = 1'b0;
                    exp_drops++;
                end else begin
                    keep = 1'b1;
                    free_slots--;
                end
                send_fragment(id, len, keep, 1'b1, 1'b0);
                tick(DEPTH + 8);
            end
            drain_mode = 2;
            wait_idle("random", 3000);
            check("random_drops", 32'(drops_seen - d0), 32'(exp_drops));
        end

`ifdef UDP_FRAGMENT_SLOT_BANK_TIMEOUT_EN
        // Stalled fragment times out; its trailing beats are ignored.
        drain_mode = 1;
        d0 = drops_seen;
        hit = 0;
        for (int b = 0; b < 3; b++) begin
            bus.data_enable = 1'b1;
            bus.data        = DW'($urandom);
            bus.data_last   = 1'b0;
            bus.fragment_id = 16'h7777;
            tick();
        end
        bus.data_enable = 1'b0;
        for (int g = 1; g <= 60; g++) begin
            tick();
            if (bus.drop && hit == 0) hit = g;
        end
        check("timeout_window", 32'(hit >= 45 && hit <= 58), 32'd1);
        check("timeout_idle", 32'(bus.slot_busy), 32'd0);
        bus.data_enable = 1'b1;
        bus.data_last   = 1'b1;
        tick();
        bus.data_enable = 1'b0;
        bus.data_last   = 1'b0;
        tick(8);
        check("timeout_one_drop", 32'(drops_seen - d0), 32'd1);
        check("timeout_still_idle", 32'(bus.slot_busy), 32'd0);
`endif

        // Reset in the middle of a drain.
        drain_mode = 2;
        send_fragment(16'h5A5A, 12, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!bus.data_ready && n < 40) begin
            tick();
            n++;
        end
        check("middrain_data_ready", 32'(bus.data_ready), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("middrain_reset");
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        tick(2);
        drain_mode = 0;
        send_fragment(16'hBEEF, 3, 1'b1, 1'b0, 1'b0);
        tick(3);
        check("post_reset_slot0", 32'(bus.slot_busy), 32'h1);
        drain_mode = 1;
        wait_idle("post_reset", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
